// File: rtl/stage3_pool_streamer_pkg.sv
// -----------------------------------------------------------------------------
// stage3_pool_streamer_pkg
// Shared constants and types for the stage-3 pool streamer and its register
// banks. POOL_CO / OF_BW mirror the FC accumulator's channel count and value
// width. STREAM_NPOS / STREAM_GAP set the frame length and the minimum number
// of idle cycles between frames.
// -----------------------------------------------------------------------------
package stage3_pool_streamer_pkg;

    localparam int POOL_CO     = 3;    // channels per pooled position
    localparam int OF_BW       = 34;   // bits per channel value (signed)
    localparam int STREAM_NPOS = 16;   // positions per frame (4x4)
    localparam int STREAM_GAP  = 2;    // idle cycles after a frame, must be >= 2

    localparam int WORD_W = POOL_CO * OF_BW;
    localparam int PTR_W  = $clog2(STREAM_NPOS);
    localparam int GAP_W  = $clog2(STREAM_GAP);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STREAM_NPOS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STREAM_GAP - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } rd_state_t;

endpackage

// File: rtl/stage3_pool_bank.sv
// -----------------------------------------------------------------------------
// stage3_pool_bank
// One frame of pooled positions: STREAM_NPOS words of WORD_W bits with a
// synchronous write port and an asynchronous read port.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write position
//   wdata  in   write word ({ch2, ch1, ch0})
//   raddr  in   read position
//   rdata  out  word at raddr (combinational)
// -----------------------------------------------------------------------------
module stage3_pool_bank
    import stage3_pool_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [STREAM_NPOS];

    // NOTE: the storage array is deliberately not reset; the bank flags in the
    // parent decide whether its contents are valid, so clearing data is wasted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stage3_pool_streamer.sv
// -----------------------------------------------------------------------------
// stage3_pool_streamer
// Captures the 4x4x3 max-pool map as the pooling stage writes it (at any pace)
// into one of two ping-pong banks, and replays each completed frame as
// STREAM_NPOS back-to-back valid beats to the FC accumulator, followed by at
// least STREAM_GAP idle cycles so the accumulator can clear its sums.
//
// Optional build macro: STAGE3_STREAM_OVF_CNT_EN adds o_ovf_cnt, a saturating
// count of cycles where a write was offered while o_wr_ready was low.
//
//   clk            in   clock
//   reset_n        in   asynchronous active-low reset
//   i_wr_valid     in   pooled position write strobe
//   i_wr_data      in   pooled position, ch0 in LSBs
//   o_wr_ready     out  write bank available (write accepted on valid&&ready)
//   o_ot_valid     out  beat valid to accumulator
//   o_ot_pooling   out  beat data (holds last value when not valid)
//   o_frame_start  out  high with beat 0 of each frame
//   o_busy         out  read FSM not idle
//   o_ovf_cnt      out  overflow count (STAGE3_STREAM_OVF_CNT_EN only)
// -----------------------------------------------------------------------------
module stage3_pool_streamer
    import stage3_pool_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_valid,
    input  logic [WORD_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_ot_valid,
    output logic [WORD_W-1:0] o_ot_pooling,
    output logic              o_frame_start,
    output logic              o_busy
`ifdef STAGE3_STREAM_OVF_CNT_EN
    ,
    output logic [15:0]       o_ovf_cnt
`endif
);

    bank_state_t       bank_st [2];
    bank_state_t       bank_st_next [2];
    logic              wr_bank, wr_bank_next;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
    logic              rd_bank, rd_bank_next;
    logic [PTR_W-1:0]  beat_cnt, beat_next;
    logic [GAP_W-1:0]  gap_cnt, gap_next;
    rd_state_t         state, state_next;
    logic              rd_done;
    logic              wr_accept;
    logic [WORD_W-1:0] rdata0, rdata1, rd_word;

    assign wr_accept = i_wr_valid && o_wr_ready;

    // Both banks read the position the next beat will present.
    stage3_pool_bank u_bank0 (
        .clk   (clk),
        .we    (wr_accept && (wr_bank == 1'b0)),
        .waddr (wr_ptr),
        .wdata (i_wr_data),
        .raddr (beat_next),
        .rdata (rdata0)
    );

    stage3_pool_bank u_bank1 (
        .clk   (clk),
        .we    (wr_accept && (wr_bank == 1'b1)),
        .waddr (wr_ptr),
        .wdata (i_wr_data),
        .raddr (beat_next),
        .rdata (rdata1)
    );

    assign rd_word = rd_bank ? rdata1 : rdata0;

    // Read FSM next state. A frame is released only when its bank is FULL, so
    // the write side (which never targets a FULL bank) cannot touch it.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next   = state;
        beat_next    = beat_cnt;
        gap_next     = gap_cnt;
        rd_bank_next = rd_bank;
        rd_done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bank_st[rd_bank] == BANK_FULL) begin
                    state_next = ST_STREAM;
                    beat_next  = '0;
                end
            end
            ST_STREAM: begin
                if (beat_cnt == PTR_LAST) begin
                    state_next   = ST_GAP;
                    rd_done      = 1'b1;
                    rd_bank_next = ~rd_bank;
                    gap_next     = '0;
                end else begin
                    beat_next = beat_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bank flags and write pointer. The bank released by rd_done is always the
    // FULL one, and an accepted write never targets a FULL bank, so the two
    // updates below never collide on the same bank.
    always_comb begin
        bank_st_next = bank_st;
        wr_ptr_next  = wr_ptr;
        wr_bank_next = wr_bank;
        if (rd_done) begin
            bank_st_next[rd_bank] = BANK_EMPTY;
        end
        if (wr_accept) begin
            if (wr_ptr == PTR_LAST) begin
                bank_st_next[wr_bank] = BANK_FULL;
                wr_ptr_next           = '0;
                wr_bank_next          = ~wr_bank;
            end else begin
                bank_st_next[wr_bank] = BANK_FILLING;
                wr_ptr_next           = wr_ptr + 1'b1;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_st[0]   <= BANK_EMPTY;
            bank_st[1]   <= BANK_EMPTY;
            wr_bank      <= 1'b0;
            wr_ptr       <= '0;
            rd_bank      <= 1'b0;
            beat_cnt     <= '0;
            gap_cnt      <= '0;
            state        <= ST_IDLE;
            o_wr_ready   <= 1'b1;
            o_ot_pooling <= '0;
        end else begin
            bank_st  <= bank_st_next;
            wr_bank  <= wr_bank_next;
            wr_ptr   <= wr_ptr_next;
            rd_bank  <= rd_bank_next;
            beat_cnt <= beat_next;
            gap_cnt  <= gap_next;
            state    <= state_next;
            // Ready is computed from the post-edge flags so the cycle after a
            // bank fills can never accept a write into a still-streaming bank.
            o_wr_ready <= (bank_st_next[wr_bank_next] != BANK_FULL);
            if (state_next == ST_STREAM) begin
                o_ot_pooling <= rd_word;
            end
        end
    end

    assign o_ot_valid    = (state == ST_STREAM);
    assign o_frame_start = (state == ST_STREAM) && (beat_cnt == '0);
    assign o_busy        = (state != ST_IDLE);

`ifdef STAGE3_STREAM_OVF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ovf_cnt <= '0;
        end else if (i_wr_valid && !o_wr_ready && (o_ovf_cnt != 16'hFFFF)) begin
            o_ovf_cnt <= o_ovf_cnt + 16'd1;
        end
    end
`endif

endmodule
